// File: rtl/button_debounce.sv
// button_debounce
//   Conditions the raw board push-button for the memory read/write controller.
//   The pin is synchronised into the clk domain and debounced. The block then
//   reports a debounced level, one-cycle press/release pulses, a long-press
//   pulse and auto-repeat pulses while the button stays held.
//
// Ports
//   clk         in   divided system clock, rising edge
//   rst         in   synchronous reset, active-high
//   button      in   raw asynchronous push-button pin, active-high
//   btn_level   out  debounced button state
//   btn_pulse   out  one-cycle pulse on accepted press
//   btn_release out  one-cycle pulse on accepted release
//   btn_long    out  one-cycle pulse when the hold reaches LONG_CYCLES
//   btn_repeat  out  one-cycle pulse every REPEAT_CYCLES after btn_long
//
// States
//   IDLE         | button released, waiting for a high sample
//   PRESS_WAIT   | counting stable high samples before accepting a press
//   PRESSED      | press accepted, counting hold time toward btn_long
//   LONG_HELD    | long press reported, generating repeat pulses
//   RELEASE_WAIT | counting stable low samples; hold/repeat counters frozen
module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int LONG_CYCLES     = 10000000,
    parameter int REPEAT_CYCLES   = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release,
    output logic btn_long,
    output logic btn_repeat
);

    localparam int MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int MAX_P  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DEB_C  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        PRESSED      = 3'd2,
        LONG_HELD    = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    state_t          state_q;
    logic [CW-1:0]   deb_cnt_q;
    logic [CW-1:0]   hold_cnt_q;
    logic [CW-1:0]   rep_cnt_q;
    logic            ret_long_q;
    logic            level_q;
    logic            pulse_q;
    logic            release_q;
    logic            long_q;
    logic            repeat_q;

    logic [CW-1:0]   deb_inc_d;
    logic [CW-1:0]   hold_inc_d;
    logic [CW-1:0]   rep_inc_d;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + ONE_C;
    endfunction

    assign deb_inc_d  = sat_inc(deb_cnt_q);
    assign hold_inc_d = sat_inc(hold_cnt_q);
    assign rep_inc_d  = sat_inc(rep_cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            ret_long_q <= 1'b0;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    level_q <= 1'b0;
                    if (btn_s) begin
                        state_q   <= PRESS_WAIT;
                        deb_cnt_q <= ONE_C;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q <= IDLE;
                    end else if (deb_cnt_q >= DEB_C) begin
                        state_q    <= PRESSED;
                        hold_cnt_q <= '0;
                        level_q    <= 1'b1;
                        pulse_q    <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_inc_d;
                    end
                end
                PRESSED: begin
                    // A low sample takes priority over reaching the long threshold.
                    if (!btn_s) begin
                        state_q    <= RELEASE_WAIT;
                        deb_cnt_q  <= ONE_C;
                        ret_long_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_inc_d;
                        if (hold_inc_d >= LONG_C) begin
                            state_q   <= LONG_HELD;
                            long_q    <= 1'b1;
                            rep_cnt_q <= '0;
                        end
                    end
                end
                LONG_HELD: begin
                    if (!btn_s) begin
                        state_q    <= RELEASE_WAIT;
                        deb_cnt_q  <= ONE_C;
                        ret_long_q <= 1'b1;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (rep_inc_d >= REP_C) begin
                            repeat_q  <= 1'b1;
                            rep_cnt_q <= '0;
                        end else begin
                            rep_cnt_q <= rep_inc_d;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // Release bounce resumes the hold without a new press pulse.
                    if (btn_s) begin
                        state_q <= ret_long_q ? LONG_HELD : PRESSED;
                    end else if (deb_cnt_q >= DEB_C) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic clk;
    logic rst;
    logic button;
    logic btn_level, btn_pulse, btn_release, btn_long, btn_repeat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    button_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .btn_repeat (btn_repeat)
    );

    // Expected {level, pulse, release, long, repeat} after each rising edge.
    logic [4:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;

    // Reference model: btn_s is the pin delayed through a queue; accepted
    // level changes after DEB+1 consecutive opposite samples; hold and repeat
    // timing are plain counts of held samples.
    bit m_sync[$];
    bit m_level;
    int m_run;
    int m_hold;
    int m_rep;
    bit m_long_done;

    task automatic model_step(input bit r, input bit b, output logic [4:0] e);
        bit s;
        bit p, rl, lg, rp;
        p = 0; rl = 0; lg = 0; rp = 0;
        if (r) begin
            m_sync = {};
            for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
            m_level = 0; m_run = 0; m_hold = 0; m_rep = 0; m_long_done = 0;
            e = '0;
            return;
        end
        s = m_sync.pop_front();
        m_sync.push_back(b);
        if (!m_level) begin
            if (s) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_level = 1; p = 1; m_run = 0; m_hold = 0; m_long_done = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (!s) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_level = 0; rl = 1; m_run = 0;
            end
        end else if (m_run > 0) begin
            m_run = 0;
        end else if (!m_long_done) begin
            m_hold++;
            if (m_hold == LONG) begin
                lg = 1; m_long_done = 1; m_rep = 0;
            end
        end else if (REP > 0) begin
            m_rep++;
            if (m_rep == REP) begin
                rp = 1; m_rep = 0;
            end
        end
        e = {m_level, p, rl, lg, rp};
    endtask

    task automatic cyc(input bit r, input bit b);
        logic [4:0] e;
        @(negedge clk);
        rst = r;
        button = b;
        model_step(r, b, e);
        exp_q.push_back(e);
    endtask

    task automatic hold_for(input bit b, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, b);
    endtask

    // Monitor: one output vector per cycle, checked against the queue head.
    initial begin
        logic [4:0] got;
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {btn_level, btn_pulse, btn_release, btn_long, btn_repeat};
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL outputs cycle %0d: got %b want %b ({level,pulse,release,long,repeat})",
                             cyc_n, got, e);
                end
                n_cmp++;
                if ((int'(btn_pulse) + int'(btn_release) + int'(btn_long)) > 1 ||
                    (btn_long && btn_repeat)) begin
                    n_err++;
                    $display("FAIL exclusive cycle %0d: got pulse=%b release=%b long=%b repeat=%b want at most one",
                             cyc_n, btn_pulse, btn_release, btn_long, btn_repeat);
                end
            end
        end
    end

    initial begin
        bit b;
        int len;
        rst = 1'b1;
        button = 1'b0;

        // Reset with button held, then a fresh press
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        hold_for(1'b1, 12);
        hold_for(1'b0, 10);

        // Bounce rejection
        begin
            bit [6:0] pat;
            pat = 7'b1011010;
            for (int i = 6; i >= 0; i--) cyc(1'b0, pat[i]);
        end
        hold_for(1'b0, 8);

        // Clean short press
        hold_for(1'b1, 10);
        hold_for(1'b0, 10);

        // Release bounce
        hold_for(1'b1, 10);
        begin
            bit [6:0] pat;
            pat = 7'b0010000;
            for (int i = 6; i >= 0; i--) cyc(1'b0, pat[i]);
        end
        hold_for(1'b0, 6);

        // Long press with repeat
        hold_for(1'b1, 50);
        hold_for(1'b0, 10);

        // Reset while long-held, button kept high
        hold_for(1'b1, 35);
        cyc(1'b1, 1'b1);
        hold_for(1'b1, 15);
        hold_for(1'b0, 10);

        // Randomised runs with occasional reset
        for (int k = 0; k < 60; k++) begin
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 6);
            else len = $urandom_range(1, 45);
            if ($urandom_range(0, 24) == 0) cyc(1'b1, b);
            hold_for(b, len);
        end
        hold_for(1'b0, 12);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
